// File: rtl/msrv32_bus_arbiter.sv
// Two-master AHB-Lite arbiter (fetch + load/store); define MSRV32_ARB_ROUND_ROBIN_EN for round-robin arbitration.
// Latency: gnt in ADDR cycle, rvalid two cycles later plus wait states; requesters hold req until gnt, bus stalls via hready_in.
module msrv32_bus_arbiter #(
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        i_req_in,
    input  logic [31:0] i_addr_in,
    output logic        i_gnt_out,
    output logic        i_rvalid_out,
    output logic [31:0] i_rdata_out,
    output logic        i_err_out,
    input  logic        d_req_in,
    input  logic        d_we_in,
    input  logic [3:0]  d_mask_in,
    input  logic [31:0] d_addr_in,
    input  logic [31:0] d_wdata_in,
    output logic        d_gnt_out,
    output logic        d_rvalid_out,
    output logic [31:0] d_rdata_out,
    output logic        d_err_out,
    output logic [31:0] haddr_out,
    output logic [1:0]  htrans_out,
    output logic        hwrite_out,
    output logic [2:0]  hsize_out,
    output logic [31:0] hwdata_out,
    input  logic [31:0] hrdata_in,
    input  logic        hready_in,
    input  logic        hresp_in
);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic [2:0]  size_q, size_d;
    logic [7:0]  wait_q, wait_d;
    logic        i_gnt_q, i_gnt_d, d_gnt_q, d_gnt_d;
    logic        i_rvalid_q, i_rvalid_d, d_rvalid_q, d_rvalid_d;
    logic [31:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
    logic        i_err_q, i_err_d, d_err_q, d_err_d;
    logic        take, fin, tout, pick_data, wait_hit;

`ifdef MSRV32_ARB_ROUND_ROBIN_EN
    logic        last_fetch_q, last_fetch_d;
    assign pick_data = d_req_in && (!i_req_in || last_fetch_q);
`else
    assign pick_data = d_req_in;
`endif

    assign wait_hit = (wait_q == WAIT_LAST);

    function automatic logic [2:0] mask_to_size(input logic [3:0] m);
        case (m)
            4'b1111:                            mask_to_size = 3'b010;
            4'b0011, 4'b1100:                   mask_to_size = 3'b001;
            4'b0001, 4'b0010, 4'b0100, 4'b1000: mask_to_size = 3'b000;
            default:                            mask_to_size = 3'b010;
        endcase
    endfunction

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        size_d     = size_q;
        wait_d     = wait_q;
        i_gnt_d    = 1'b0;
        d_gnt_d    = 1'b0;
        i_rvalid_d = 1'b0;
        d_rvalid_d = 1'b0;
        i_rdata_d  = i_rdata_q;
        d_rdata_d  = d_rdata_q;
        i_err_d    = i_err_q;
        d_err_d    = d_err_q;
`ifdef MSRV32_ARB_ROUND_ROBIN_EN
        last_fetch_d = last_fetch_q;
`endif
        take = 1'b0;
        fin  = 1'b0;
        tout = 1'b0;

        case (state_q)
            S_IDLE: take = i_req_in | d_req_in;
            S_ADDR: begin
                if (hready_in)     state_d = S_DATA;
                else if (wait_hit) tout = 1'b1;
                else               wait_d = wait_q + 8'd1;
            end
            S_DATA: begin
                if (hready_in) begin
                    fin  = 1'b1;
                    take = i_req_in | d_req_in;
                    if (!take) state_d = S_IDLE;
                end else if (wait_hit) begin
                    tout = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A timeout aborts to IDLE and reports an error with zeroed data.
        if (tout) begin
            state_d = S_IDLE;
            wait_d  = wait_q + 8'd1;
        end

        if (fin || tout) begin
            if (owner_q) begin
                d_rvalid_d = 1'b1;
                d_rdata_d  = fin ? hrdata_in : 32'h0;
                d_err_d    = fin ? hresp_in : 1'b1;
            end else begin
                i_rvalid_d = 1'b1;
                i_rdata_d  = fin ? hrdata_in : 32'h0;
                i_err_d    = fin ? hresp_in : 1'b1;
            end
        end

        if (take) begin
            state_d = S_ADDR;
            wait_d  = 8'd0;
            owner_d = pick_data;
`ifdef MSRV32_ARB_ROUND_ROBIN_EN
            last_fetch_d = !pick_data;
`endif
            if (pick_data) begin
                addr_d  = d_addr_in;
                we_d    = d_we_in;
                size_d  = mask_to_size(d_mask_in);
                wdata_d = d_wdata_in;
                d_gnt_d = 1'b1;
            end else begin
                addr_d  = i_addr_in;
                we_d    = 1'b0;
                size_d  = 3'b010;
                wdata_d = 32'h0;
                i_gnt_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= S_IDLE;
            owner_q    <= 1'b0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            we_q       <= 1'b0;
            size_q     <= 3'b000;
            wait_q     <= 8'd0;
            i_gnt_q    <= 1'b0;
            d_gnt_q    <= 1'b0;
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            i_rdata_q  <= 32'h0;
            d_rdata_q  <= 32'h0;
            i_err_q    <= 1'b0;
            d_err_q    <= 1'b0;
`ifdef MSRV32_ARB_ROUND_ROBIN_EN
            last_fetch_q <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            size_q     <= size_d;
            wait_q     <= wait_d;
            i_gnt_q    <= i_gnt_d;
            d_gnt_q    <= d_gnt_d;
            i_rvalid_q <= i_rvalid_d;
            d_rvalid_q <= d_rvalid_d;
            i_rdata_q  <= i_rdata_d;
            d_rdata_q  <= d_rdata_d;
            i_err_q    <= i_err_d;
            d_err_q    <= d_err_d;
`ifdef MSRV32_ARB_ROUND_ROBIN_EN
            last_fetch_q <= last_fetch_d;
`endif
        end
    end

    // Bus fields are gated by phase so idle cycles present a quiet bus.
    assign htrans_out   = (state_q == S_ADDR) ? 2'b10 : 2'b00;
    assign haddr_out    = (state_q == S_ADDR) ? addr_q : 32'h0;
    assign hwrite_out   = (state_q == S_ADDR) && we_q;
    assign hsize_out    = (state_q == S_ADDR) ? size_q : 3'b000;
    assign hwdata_out   = (state_q == S_DATA) ? wdata_q : 32'h0;

    assign i_gnt_out    = i_gnt_q;
    assign d_gnt_out    = d_gnt_q;
    assign i_rvalid_out = i_rvalid_q;
    assign d_rvalid_out = d_rvalid_q;
    assign i_rdata_out  = i_rdata_q;
    assign d_rdata_out  = d_rdata_q;
    assign i_err_out    = i_err_q;
    assign d_err_out    = d_err_q;

endmodule

// File: tb/tb_msrv32_bus_arbiter.sv
// Directed bench for msrv32_bus_arbiter with a response scoreboard; expectations follow
// the arbitration mode selected by MSRV32_ARB_ROUND_ROBIN_EN.
module tb_msrv32_bus_arbiter;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        i_req_in, d_req_in, d_we_in, hready_in, hresp_in;
    logic [31:0] i_addr_in, d_addr_in, d_wdata_in, hrdata_in;
    logic [3:0]  d_mask_in;
    logic        i_gnt_out, i_rvalid_out, i_err_out, d_gnt_out, d_rvalid_out, d_err_out, hwrite_out;
    logic [31:0] i_rdata_out, d_rdata_out, haddr_out, hwdata_out;
    logic [1:0]  htrans_out;
    logic [2:0]  hsize_out;

    typedef struct packed {
        logic        is_data;
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t exp_q[$];
    rsp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    logic [3:0] mk_tab [7] = '{4'hF, 4'h3, 4'hC, 4'h1, 4'h8, 4'h5, 4'h6};
    logic [2:0] sz_tab [7] = '{3'b010, 3'b001, 3'b001, 3'b000, 3'b000, 3'b010, 3'b010};
    logic       arb_exp [4];

    msrv32_bus_arbiter #(.MAX_WAIT(16)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in),
        .i_req_in(i_req_in), .i_addr_in(i_addr_in), .i_gnt_out(i_gnt_out),
        .i_rvalid_out(i_rvalid_out), .i_rdata_out(i_rdata_out), .i_err_out(i_err_out),
        .d_req_in(d_req_in), .d_we_in(d_we_in), .d_mask_in(d_mask_in), .d_addr_in(d_addr_in),
        .d_wdata_in(d_wdata_in), .d_gnt_out(d_gnt_out), .d_rvalid_out(d_rvalid_out),
        .d_rdata_out(d_rdata_out), .d_err_out(d_err_out),
        .haddr_out(haddr_out), .htrans_out(htrans_out), .hwrite_out(hwrite_out),
        .hsize_out(hsize_out), .hwdata_out(hwdata_out), .hrdata_in(hrdata_in),
        .hready_in(hready_in), .hresp_in(hresp_in)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic push_rsp(input logic is_data, input logic [31:0] rdata, input logic err);
        rsp_t e;
        e.is_data = is_data;
        e.rdata   = rdata;
        e.err     = err;
        exp_q.push_back(e);
    endtask

    // Responses are matched in order against what the stimulus predicted.
    always @(negedge clk_in) begin
        if (rst_n_in) begin
            if (i_gnt_out || d_gnt_out) chk("gnt excl", 32'(i_gnt_out & d_gnt_out), 32'h0);
            if (i_rvalid_out || d_rvalid_out) begin
                chk("rvalid excl", 32'(i_rvalid_out & d_rvalid_out), 32'h0);
                if (exp_q.size() == 0) begin
                    chk("rvalid unexpected", 32'({i_rvalid_out, d_rvalid_out}), 32'h0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("rsp owner", 32'(d_rvalid_out), 32'(mon_e.is_data));
                    chk("rsp rdata", mon_e.is_data ? d_rdata_out : i_rdata_out, mon_e.rdata);
                    chk("rsp err", 32'(mon_e.is_data ? d_err_out : i_err_out), 32'(mon_e.err));
                end
            end
        end
    end

    task automatic wait_gnt(input string tag, input logic is_data, output logic got);
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk_in);
            got = is_data ? d_gnt_out : i_gnt_out;
        end
        chk({tag, " gnt"}, 32'(got), 32'h1);
    endtask

    task automatic xfer(input string tag, input logic is_data, input logic we, input logic [3:0] mask,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                        input logic resp, input int waits, input logic [2:0] exp_size);
        logic got;
        if (is_data) begin
            d_req_in = 1'b1; d_we_in = we; d_mask_in = mask; d_addr_in = addr; d_wdata_in = wdata;
        end else begin
            i_req_in = 1'b1; i_addr_in = addr;
        end
        hrdata_in = rdata; hready_in = 1'b1; hresp_in = 1'b0;
        push_rsp(is_data, rdata, resp);
        wait_gnt(tag, is_data, got);
        if (!got) begin
            i_req_in = 1'b0; d_req_in = 1'b0;
            return;
        end
        chk({tag, " other gnt"}, 32'(is_data ? i_gnt_out : d_gnt_out), 32'h0);
        chk({tag, " htrans"}, 32'(htrans_out), 32'h2);
        chk({tag, " haddr"}, haddr_out, addr);
        chk({tag, " hwrite"}, 32'(hwrite_out), 32'(we & is_data));
        chk({tag, " hsize"}, 32'(hsize_out), 32'(exp_size));
        i_req_in = 1'b0; d_req_in = 1'b0;
        @(negedge clk_in);
        chk({tag, " data htrans"}, 32'(htrans_out), 32'h0);
        if (is_data && we) chk({tag, " hwdata"}, hwdata_out, wdata);
        hresp_in  = resp;
        hready_in = (waits == 0);
        for (int k = 1; k <= waits; k++) begin
            @(negedge clk_in);
            chk({tag, " early rvalid"}, 32'(is_data ? d_rvalid_out : i_rvalid_out), 32'h0);
            hready_in = (k == waits);
        end
        @(negedge clk_in);
        chk({tag, " rvalid"}, 32'(is_data ? d_rvalid_out : i_rvalid_out), 32'h1);
        hresp_in = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic got;
`ifdef MSRV32_ARB_ROUND_ROBIN_EN
        arb_exp = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        arb_exp = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        rst_n_in = 1'b0;
        i_req_in = 1'b0; i_addr_in = 32'h0;
        d_req_in = 1'b0; d_we_in = 1'b0; d_mask_in = 4'h0; d_addr_in = 32'h0; d_wdata_in = 32'h0;
        hrdata_in = 32'h0; hready_in = 1'b1; hresp_in = 1'b0;

        @(negedge clk_in);
        chk("rst htrans", 32'(htrans_out), 32'h0);
        chk("rst gnt", 32'({i_gnt_out, d_gnt_out}), 32'h0);
        chk("rst rvalid", 32'({i_rvalid_out, d_rvalid_out}), 32'h0);
        chk("rst haddr", haddr_out, 32'h0);
        chk("rst hwdata", hwdata_out, 32'h0);
        chk("rst rdata", i_rdata_out | d_rdata_out, 32'h0);
        chk("rst err", 32'({i_err_out, d_err_out, hwrite_out}), 32'h0);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        @(negedge clk_in);

        xfer("fetch", 1'b0, 1'b0, 4'h0, 32'h0000_0100, 32'h0, 32'h0000_0013, 1'b0, 0, 3'b010);
        xfer("bstore", 1'b1, 1'b1, 4'b0100, 32'h0000_2002, 32'h00AB_0000, 32'h0, 1'b0, 2, 3'b000);
        for (int n = 0; n < 7; n++)
            xfer($sformatf("size%0d", n), 1'b1, 1'b0, mk_tab[n], 32'h1000 + 32'(n * 4), 32'h0,
                 32'hA000 + 32'(n), 1'b0, n % 2, sz_tab[n]);
        xfer("errload", 1'b1, 1'b0, 4'hF, 32'h0000_3000, 32'h0, 32'hBAD0_0001, 1'b1, 1, 3'b010);

        // Timeout: DATA phase stalled for MAX_WAIT cycles.
        d_req_in = 1'b1; d_we_in = 1'b0; d_mask_in = 4'hF; d_addr_in = 32'h4000;
        hready_in = 1'b1; hrdata_in = 32'hFFFF_FFFF;
        push_rsp(1'b1, 32'h0, 1'b1);
        wait_gnt("tmo", 1'b1, got);
        d_req_in = 1'b0;
        @(negedge clk_in);
        hready_in = 1'b0;
        for (int k = 1; k <= 15; k++) @(negedge clk_in);
        chk("tmo early rvalid", 32'(d_rvalid_out), 32'h0);
        @(negedge clk_in);
        chk("tmo rvalid", 32'(d_rvalid_out), 32'h1);
        chk("tmo err", 32'(d_err_out), 32'h1);
        chk("tmo rdata", d_rdata_out, 32'h0);
        chk("tmo htrans", 32'(htrans_out), 32'h0);
        hready_in = 1'b1;
        @(negedge clk_in);
        chk("tmo rvalid pulse", 32'(d_rvalid_out), 32'h0);
        xfer("after tmo", 1'b0, 1'b0, 4'h0, 32'h0000_0140, 32'h0, 32'h0000_0093, 1'b0, 0, 3'b010);

        // Reset asserted during the ADDR phase of a fetch.
        i_req_in = 1'b1; i_addr_in = 32'h500; hready_in = 1'b1;
        wait_gnt("rst abort", 1'b0, got);
        chk("rst abort htrans pre", 32'(htrans_out), 32'h2);
        i_req_in = 1'b0;
        #1 rst_n_in = 1'b0;
        #1;
        chk("rst abort htrans", 32'(htrans_out), 32'h0);
        chk("rst abort haddr", haddr_out, 32'h0);
        chk("rst abort gnt", 32'(i_gnt_out), 32'h0);
        @(negedge clk_in);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_in);
            chk("rst abort no rvalid", 32'(i_rvalid_out), 32'h0);
        end
        xfer("fetch after rst", 1'b0, 1'b0, 4'h0, 32'h0000_0600, 32'h0, 32'h1234_5678, 1'b0, 0, 3'b010);

        // Both requesters held high across four back-to-back transfers.
        i_req_in = 1'b1; i_addr_in = 32'h700;
        d_req_in = 1'b1; d_we_in = 1'b0; d_mask_in = 4'hF; d_addr_in = 32'h800;
        hrdata_in = 32'h5555_AAAA; hready_in = 1'b1; hresp_in = 1'b0;
        for (int n = 0; n < 4; n++) push_rsp(arb_exp[n], 32'h5555_AAAA, 1'b0);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk_in);
            if (c % 2 == 0)
                chk($sformatf("arb gnt%0d", c / 2), 32'({d_gnt_out, i_gnt_out}),
                    arb_exp[c / 2] ? 32'h2 : 32'h1);
            if (c == 7) begin
                i_req_in = 1'b0; d_req_in = 1'b0;
            end
        end
        @(negedge clk_in);
        @(negedge clk_in);
        @(negedge clk_in);

        chk("scoreboard drained", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/msrv32_bus_arbiter.md
# msrv32_bus_arbiter

Two-master AHB-Lite arbiter for the msrv32 core. It shares one AHB-Lite master port between the instruction-fetch requester and the data load/store requester. It serialises single transfers, drives the address and data phases, returns read data and error status to the granted requester, and aborts transfers that stall past a wait limit. It sits between the core's fetch/store/load units and the system bus.

## Interface
- MAX_WAIT, 16: maximum consecutive hready_in-low cycles in one transfer before timeout abort; range 2..255.
- clk_in  in  1  core clock; all state on rising edge.
- rst_n_in  in  1  asynchronous active-low reset.
- i_req_in  in  1  fetch request; held high with i_addr_in stable until i_gnt_out.
- i_addr_in  in  32  fetch address (word aligned).
- i_gnt_out  out  1  one-cycle pulse: fetch request accepted.
- i_rvalid_out  out  1  one-cycle pulse: fetch complete; i_rdata_out valid.
- i_rdata_out  out  32  fetched instruction word.
- i_err_out  out  1  qualifies i_rvalid_out: bus error or timeout.
- d_req_in  in  1  data request; held with all d_* fields stable until d_gnt_out.
- d_we_in  in  1  1 = store, 0 = load.
- d_mask_in  in  4  byte lanes; selects hsize_out.
- d_addr_in  in  32  data address.
- d_wdata_in  in  32  store data.
- d_gnt_out, d_rvalid_out, d_rdata_out[31:0], d_err_out  out  semantics as fetch side.
- haddr_out  out  32  AHB address.
- htrans_out  out  2  00 IDLE / 10 NONSEQ only.
- hwrite_out  out  1  AHB write.
- hsize_out  out  3  000 byte, 001 half, 010 word.
- hwdata_out  out  32  AHB write data, valid in data phase.
- hrdata_in  in  32  AHB read data.
- hready_in  in  1  AHB ready.
- hresp_in  in  1  AHB response; 1 = ERROR.

## Operation
- FSM states:
  - IDLE: htrans_out=00.
  - ADDR: htrans_out=10, haddr/hwrite/hsize driven from the captured request.
  - DATA: htrans_out=00, hwdata_out driven from the captured d_wdata.
- IDLE -> ADDR when any request is high. The chosen requester's gnt pulses in the same cycle. Its fields are registered on that edge.
- ADDR -> DATA on a cycle with hready_in=1. ADDR holds while hready_in=0.
- DATA completes on a cycle with hready_in=1:
  - read data and hresp_in are registered into the owner's rdata/err; rvalid pulses the next cycle.
  - If another request is pending, go directly to ADDR with a new grant; otherwise go to IDLE.
- Arbitration with both requests high: data wins (fixed priority). Fetch can be starved under continuous data traffic.
- hsize from d_mask_in:
  - 1111 -> 010.
  - 0011 or 1100 -> 001.
  - single bit -> 000.
  - any other mask -> 010.
  - Fetch is always 010, hwrite=0.
- Timeout: a counter clears on entry to ADDR and increments each hready_in-low cycle in ADDR/DATA. On reaching MAX_WAIT:
  - go to IDLE;
  - owner's rvalid and err pulse next cycle with rdata=0.
- ERROR response: hresp_in sampled on the completing cycle (hready_in=1). err=1 and rdata=hrdata_in are forwarded unchanged.
- Requests dropped before gnt are ignored. Requests are sampled only at decision points (IDLE, or DATA completion).

## Timing
- Reset values: all outputs 0, htrans_out=00, state IDLE, timeout counter 0, round-robin pointer "fetch last". Applied asynchronously on rst_n_in low; release is synchronous to clk_in.
- Minimum latency with zero wait states:
  - gnt at cycle 0, ADDR cycle 0, DATA cycle 1, rvalid cycle 2.
  - Back-to-back throughput: one transfer per 2 cycles.
- Each wait state adds 1 cycle of latency.
- gnt and rvalid never pulse for both requesters in the same cycle.
- Reset mid-transfer: FSM returns to IDLE immediately. No rvalid or err is issued for the aborted transfer.
- gnt for the next transfer may coincide with rvalid of the previous transfer.

## Configuration
- MSRV32_ARB_ROUND_ROBIN_EN defined: when both requests are high at a decision point, grant the requester not granted last. The pointer updates on every grant.
- Undefined: fixed data-over-fetch priority. No pointer register is present.

## Test plan
- Single fetch, addr 0x0000_0100, hrdata 0x0000_0013, zero wait -> i_gnt cycle 0, ADDR haddr=0x100 htrans=10 hsize=010, i_rvalid cycle 2 with i_rdata=0x13, i_err=0.
- Byte store, mask 0100, addr 0x2002, wdata 0x00AB_0000, 2 wait states in DATA -> hwrite=1, hsize=000, hwdata=0x00AB0000 in DATA, d_rvalid cycle 4, d_err=0.
- Both requesters continuously high, 4 transfers:
  - macro off -> all 4 grants to data.
  - macro on -> grants alternate D, I, D, I.
- hresp_in=1 with hready_in low 1 cycle, then high, on a data load -> d_rvalid with d_err=1.
- hready_in held low in DATA with MAX_WAIT=16:
  - after 16 low cycles -> state IDLE, htrans=00;
  - next cycle owner rvalid=1, err=1, rdata=0.
- Assert rst_n_in low during ADDR of a fetch -> htrans_out=00 with no clock edge, no i_rvalid afterward, and a fresh fetch after release gets i_gnt normally.
